if_fetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the byte-wide memory controller. It issues byte addresses on the instruction-fetch port and assembles four consecutive little-endian bytes into a 32-bit instruction. It presents that instruction with its PC to the IF/ID boundary through a valid/stall handshake. It yields the RAM port whenever the MEM stage owns it, honours branch/jump redirects at any point, and freezes entirely while `rdy` is low.

---
 rtl/if_fetch.sv | 149 ++++++++++++++
 tb/tb_if_fetch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch stage. Issues four consecutive byte reads
//               to the memory controller, assembles them little-endian into
//               a 32-bit instruction and hands it to ID via valid/stall.
//               Yields the RAM port to MEM, honours redirects at any time and
//               freezes completely while rdy is low.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter logic [31:0] START_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic [31:0] addr_to_memctrl,
  input  logic [7:0]  data_from_memctrl,
  input  logic        mem_busy,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        stall_from_id,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam logic [0:0] c_FETCH = 1'b0;
  localparam logic [0:0] c_HOLD  = 1'b1;

  logic [31:0] r_pc;
  logic [2:0]  r_issue_cnt;
  logic [2:0]  r_recv_cnt;
  logic        r_pending;
  logic [23:0] r_byte_buf;
  logic [0:0]  r_state;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;

  logic        w_issuing;
  logic        w_grant;
  logic        w_last_byte;
  logic        w_consume;

  // Still has byte addresses left to put on the port for this instruction.
  assign w_issuing   = (r_state == c_FETCH) && (r_issue_cnt < 3'd4);
  // The controller accepts our address only when MEM is not using the port.
  assign w_grant     = w_issuing && !mem_busy;
  // The byte arriving now completes the instruction.
  assign w_last_byte = (r_state == c_FETCH) && r_pending && (r_recv_cnt == 3'd3);
  // ID takes the held instruction this cycle.
  assign w_consume   = (r_state == c_HOLD) && !stall_from_id;

  // Byte address: next byte of the current instruction, else the PC itself.
  always_comb begin
    addr_to_memctrl = r_pc;
    if (rst) begin
      addr_to_memctrl = START_PC;
    end else if (w_issuing) begin
      addr_to_memctrl = r_pc + {29'b0, r_issue_cnt};
    end
  end

  // Fetch control: PC, issue/receive counters, outstanding-byte flag and FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= START_PC;
      r_issue_cnt <= 3'd0;
      r_recv_cnt  <= 3'd0;
      r_pending   <= 1'b0;
      r_state     <= c_FETCH;
    end else if (rdy) begin
      if (jump_en) begin
        r_pc        <= jump_addr;
        r_issue_cnt <= 3'd0;
        r_recv_cnt  <= 3'd0;
        r_pending   <= 1'b0;
        r_state     <= c_FETCH;
      end else begin
        case (r_state)
          c_FETCH: begin
            r_pending <= w_grant;
            if (w_grant) begin
              r_issue_cnt <= r_issue_cnt + 3'd1;
            end
            if (r_pending) begin
              r_recv_cnt <= r_recv_cnt + 3'd1;
            end
            if (w_last_byte) begin
              r_state <= c_HOLD;
            end
          end
          c_HOLD: begin
            r_pending <= 1'b0;
            if (w_consume) begin
              r_pc        <= r_pc + 32'd4;
              r_issue_cnt <= 3'd0;
              r_recv_cnt  <= 3'd0;
              r_state     <= c_FETCH;
            end
          end
          default: begin
            r_state <= c_FETCH;
          end
        endcase
      end
    end
  end

  // Capture the first three returned bytes into their little-endian lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_buf <= 24'h0;
    end else if (rdy && !jump_en && (r_state == c_FETCH) && r_pending) begin
      case (r_recv_cnt)
        3'd0:    r_byte_buf[7:0]   <= data_from_memctrl;
        3'd1:    r_byte_buf[15:8]  <= data_from_memctrl;
        3'd2:    r_byte_buf[23:16] <= data_from_memctrl;
        default: r_byte_buf        <= r_byte_buf;
      endcase
    end
  end

  // IF/ID boundary registers: load on the fourth byte, drop on consume/jump.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_inst  <= 32'h0;
    end else if (rdy) begin
      if (jump_en) begin
        r_if_valid <= 1'b0;
      end else if (w_last_byte) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_pc;
        r_if_inst  <= {data_from_memctrl, r_byte_buf};
      end else if (w_consume) begin
        r_if_valid <= 1'b0;
      end
    end
  end

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_inst  = r_if_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch. A transaction-level model
//               predicts the address stream and the IF/ID outputs; assembled
//               instructions are predicted straight from the memory contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  localparam logic [31:0] START_PC = 32'h0;
  localparam logic [31:0] HI_PC    = 32'hFFFFFFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] addr_to_memctrl;
  logic [7:0]  data_from_memctrl;
  logic        mem_busy;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        stall_from_id;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  logic [31:0] hi_addr;
  logic [7:0]  hi_data;
  logic        hi_valid;
  logic [31:0] hi_pc;
  logic [31:0] hi_inst;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [31:0] m_pc;
  int          m_iss;
  int          m_rcv;
  bit          m_pend;
  bit          m_hold;
  bit          m_valid;
  logic [31:0] m_ipc;
  logic [31:0] m_inst;
  logic [7:0]  data_due;
  logic [7:0]  hi_data_due;

  always #5 clk = ~clk;

  if_fetch #(.START_PC(START_PC)) u_dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .addr_to_memctrl(addr_to_memctrl), .data_from_memctrl(data_from_memctrl),
    .mem_busy(mem_busy), .jump_en(jump_en), .jump_addr(jump_addr),
    .stall_from_id(stall_from_id),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  // Second instance starting near the top of the address space, free running.
  if_fetch #(.START_PC(HI_PC)) u_dut_hi (
    .clk(clk), .rst(rst), .rdy(1'b1),
    .addr_to_memctrl(hi_addr), .data_from_memctrl(hi_data),
    .mem_busy(1'b0), .jump_en(1'b0), .jump_addr(32'h0),
    .stall_from_id(1'b0),
    .if_valid(hi_valid), .if_pc(hi_pc), .if_inst(hi_inst)
  );

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h0) return 8'h13;
    if (a < 32'h4)  return 8'h00;
    h = a * 32'h9E3779B1;
    return h[31:24] ^ a[7:0];
  endfunction

  function automatic logic [31:0] fetch32(input logic [31:0] a);
    return {ram_byte(a + 32'd3), ram_byte(a + 32'd2), ram_byte(a + 32'd1), ram_byte(a)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model.
  task automatic cyc(input logic i_rst, input logic i_rdy, input logic i_busy,
                     input logic i_jmp, input logic [31:0] i_ja, input logic i_stall);
    logic [31:0] ea;
    bit          grant;
    @(negedge clk);
    rst               = i_rst;
    rdy               = i_rdy;
    mem_busy          = i_busy;
    jump_en           = i_jmp;
    jump_addr         = i_ja;
    stall_from_id     = i_stall;
    data_from_memctrl = data_due;
    hi_data           = hi_data_due;
    #1;
    if (i_rst)                    ea = START_PC;
    else if (!m_hold && m_iss < 4) ea = m_pc + 32'(m_iss);
    else                          ea = m_pc;
    check("addr", addr_to_memctrl, ea);
    check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    check("if_pc", if_pc, m_ipc);
    check("if_inst", if_inst, m_inst);

    // memory environment: one-cycle read latency, garbage when not serviced
    if (i_rst)       data_due = 8'($urandom);
    else if (i_rdy)  data_due = i_busy ? 8'($urandom) : ram_byte(addr_to_memctrl);
    hi_data_due = i_rst ? 8'($urandom) : ram_byte(hi_addr);

    if (i_rst) begin
      m_pc = START_PC; m_iss = 0; m_rcv = 0; m_pend = 0; m_hold = 0;
      m_valid = 0; m_ipc = 32'h0; m_inst = 32'h0;
    end else if (i_rdy) begin
      if (i_jmp) begin
        m_pc = i_ja; m_iss = 0; m_rcv = 0; m_pend = 0; m_hold = 0; m_valid = 0;
      end else if (m_hold) begin
        if (!i_stall) begin
          m_valid = 0; m_hold = 0; m_pc = m_pc + 32'd4; m_iss = 0; m_rcv = 0;
        end
      end else begin
        grant = (m_iss < 4) && !i_busy;
        if (m_pend) m_rcv++;
        m_pend = grant;
        if (grant) m_iss++;
        if (m_rcv == 4) begin
          m_hold = 1; m_valid = 1; m_ipc = m_pc; m_inst = fetch32(m_pc);
        end
      end
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; mem_busy = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
    stall_from_id = 1'b0; data_from_memctrl = 8'h0; hi_data = 8'h0;
    data_due = 8'h0; hi_data_due = 8'h0;
    m_pc = START_PC; m_iss = 0; m_rcv = 0; m_pend = 0; m_hold = 0;
    m_valid = 0; m_ipc = 32'h0; m_inst = 32'h0;

    // reset state and basic fetch, stall hold, consume, wrap on the hi instance
    do_reset();
    do_reset();
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("hi_rst_addr", hi_addr, 32'hFFFFFFFC);
    for (int c = 0; c < 12; c++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, (c >= 5 && c <= 7));
      case (c)
        0: begin check("c0_addr", addr_to_memctrl, 32'h0); check("hi_c0_addr", hi_addr, 32'hFFFFFFFC); end
        1: check("c1_addr", addr_to_memctrl, 32'h1);
        2: check("c2_addr", addr_to_memctrl, 32'h2);
        3: begin check("c3_addr", addr_to_memctrl, 32'h3); check("hi_c3_addr", hi_addr, 32'hFFFFFFFF); end
        4: check("c4_valid", {31'b0, if_valid}, 32'h0);
        5: begin
          check("c5_valid", {31'b0, if_valid}, 32'h1);
          check("c5_inst", if_inst, 32'h00000013);
          check("c5_pc", if_pc, 32'h0);
          check("hi_c5_valid", {31'b0, hi_valid}, 32'h1);
          check("hi_c5_pc", hi_pc, 32'hFFFFFFFC);
        end
        6: check("hi_c6_addr", hi_addr, 32'h0);
        7: begin check("stall_valid", {31'b0, if_valid}, 32'h1); check("stall_inst", if_inst, 32'h00000013); end
        8: check("c8_valid", {31'b0, if_valid}, 32'h1);
        9: begin
          check("next_addr", addr_to_memctrl, 32'h4);
          check("c9_valid", {31'b0, if_valid}, 32'h0);
          check("hi_c9_addr", hi_addr, 32'h3);
        end
        11: begin
          check("hi_wrap_valid", {31'b0, hi_valid}, 32'h1);
          check("hi_wrap_pc", hi_pc, 32'h0);
          check("hi_wrap_inst", hi_inst, 32'h00000013);
        end
        default: ;
      endcase
    end

    // mem_busy during issue adds one cycle
    do_reset();
    for (int c = 0; c < 7; c++) begin
      cyc(1'b0, 1'b1, (c == 1), 1'b0, 32'h0, 1'b0);
      if (c == 2) check("busy_re_addr", addr_to_memctrl, 32'h1);
      if (c == 3) check("busy_c3_addr", addr_to_memctrl, 32'h2);
      if (c == 5) check("busy_c5_valid", {31'b0, if_valid}, 32'h0);
      if (c == 6) begin
        check("busy_c6_valid", {31'b0, if_valid}, 32'h1);
        check("busy_c6_inst", if_inst, 32'h00000013);
      end
    end

    // redirect mid-fetch
    do_reset();
    for (int c = 0; c < 9; c++) begin
      cyc(1'b0, 1'b1, 1'b0, (c == 2), 32'h100, 1'b1);
      if (c == 2) check("jmp_c2_addr", addr_to_memctrl, 32'h2);
      if (c == 3) check("jmp_c3_addr", addr_to_memctrl, 32'h100);
      if (c == 6) check("jmp_c6_addr", addr_to_memctrl, 32'h103);
      if (c == 7) check("jmp_c7_valid", {31'b0, if_valid}, 32'h0);
      if (c == 8) begin
        check("jmp_valid", {31'b0, if_valid}, 32'h1);
        check("jmp_pc", if_pc, 32'h100);
      end
    end

    // rdy low for two cycles mid-fetch
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc(1'b0, !(c == 2 || c == 3), 1'b0, 1'b0, 32'h0, 1'b0);
      if (c == 3) check("frz_c3_addr", addr_to_memctrl, 32'h2);
      if (c == 5) check("frz_c5_addr", addr_to_memctrl, 32'h3);
      if (c == 6) check("frz_c6_valid", {31'b0, if_valid}, 32'h0);
      if (c == 7) begin
        check("frz_c7_valid", {31'b0, if_valid}, 32'h1);
        check("frz_c7_inst", if_inst, 32'h00000013);
      end
    end

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic        r_rst, r_rdy, r_busy, r_jmp, r_stall;
      logic [31:0] r_ja;
      r_rst   = ($urandom_range(0, 199) == 0);
      r_rdy   = ($urandom_range(0, 99) < 85);
      r_busy  = ($urandom_range(0, 99) < 30);
      r_jmp   = ($urandom_range(0, 99) < 4);
      r_stall = ($urandom_range(0, 99) < 40);
      r_ja    = $urandom_range(0, 1) ? $urandom : (32'hFFFFFFF0 + 32'($urandom_range(0, 15)));
      cyc(r_rst, r_rdy, r_busy, r_jmp, r_ja, r_stall);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
